pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel PWM generator: one shared period counter drives `Channels` independent comparators. Each channel has a duty cycle that software-side logic loads through a valid/ready port. Duty updates are double-buffered and committed only at the period boundary, so no output glitches or runt pulses occur. It replaces the fixed-table single-LED PWM and feeds LED and heater drive pins in the bolometer front end.

## Interface
- `Width`, 8: counter and duty width in bits
- `Channels`, 4: number of PWM outputs, 1..16
- `Period`, 100: counter length in clocks; 2 ≤ `Period` ≤ 2**`Width`
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset; one clock, reset is asynchronous and active-low
- `en_i`  in  1  run enable; low holds the counter at 0
- `cfg_valid_i`  in  1  duty write request
- `cfg_ready_o`  out  1  duty write accept
- `cfg_ch_i`  in  $clog2(Channels) (min 1)  target channel index
- `cfg_duty_i`  in  `Width`  new duty in counts
- `pwm_o`  out  `Channels`  registered PWM outputs
- `period_end_o`  out  1  one-cycle pulse at each period wrap

## Operation
- Counter `cnt`, `Width` bits, reset 0.
- Edge-aligned mode, when `en_i`=1: `cnt` goes 0,1,…,`Period`-1, then 0.
- Each channel holds two registers, `pend` and `act`. Both reset to 0.
- A write happens when `cfg_valid_i && cfg_ready_o`. It stores `cfg_duty_i` into `pend[cfg_ch_i]`.
  - A later write before commit overwrites the earlier one (last wins).
  - A write with `cfg_ch_i` ≥ `Channels` is accepted and dropped.
- Commit: on the edge where `cnt`==`Period`-1 and `en_i`=1, `act` ← `pend` for all channels at once.
- Comparator: `pwm_o[k]` is registered ← (`cnt` < `act[k]`).
  - `act`=0 gives a constant low output.
  - `act` ≥ `Period` gives a constant high output.
- `cfg_ready_o` = 0 during reset and in the commit cycle (`cnt`==`Period`-1 && `en_i`). Otherwise it is 1. This prevents a write racing the commit.
- When `en_i`=0:
  - `cnt` ← 0 and `pwm_o` ← 0.
  - `act` ← `pend` every cycle, so a restart uses the latest duty.
  - `period_end_o` = 0.
- When `en_i` rises, counting starts from 0 with no partial period.
- When `rst_ni` falls mid-period, all registers clear immediately and outputs go low. After release, counting starts at 0 if `en_i` is high.

## Timing
- Reset values: `pwm_o`=0, `period_end_o`=0, `cfg_ready_o`=0, `cnt`=0, all `pend` and `act`=0.
- `cfg_ready_o` rises on the first clock after `rst_ni` deasserts.
- `pwm_o` lags `cnt` by 1 cycle.
- A duty written in cycle t takes effect on `pwm_o` at the second edge after the next commit.
- `period_end_o` is registered. It is high exactly in the cycle where `cnt`==0 following a wrap, and never in the first cycle after enable.
- The high time per period equals min(`act`, `Period`) clocks.

## Configuration
- `PWM_CENTER_EN` defined: the counter runs as a triangle.
  - Sequence is 0 up to `Period`-1, then down through `Period`-2 to 1. The period is 2·`Period`-2 clocks.
  - The output rule is unchanged: high while `cnt` < `act`.
  - Commit and `period_end_o` occur at the down-count wrap 1→0.
  - `cfg_ready_o` is low in the cycle where `cnt`==1 while counting down. An extra direction flop resets to "up".
- `PWM_CENTER_EN` undefined: edge-aligned behaviour only, with no direction flop.

## Structure
- Package `pwm_pkg` holds:
  - the default `Width`, `Channels`, and `Period` constants;
  - the channel-index width function;
  - the count-direction encoding (`UP`=1'b0, `DOWN`=1'b1).
- Sub-module `pwm_channel` (one per channel, generate loop) holds `pend`, `act`, and the output comparator flop. Its inputs are `cnt`, the commit strobe, the write strobe, and the duty.
- The top level holds the counter, the direction flop, ready/commit generation, and channel decode.

## Test plan
- Reset: hold `rst_ni`=0 with `en_i`=1 → `pwm_o`=0, `period_end_o`=0, `cfg_ready_o`=0. Release → `cfg_ready_o`=1 on the next edge.
- Duty sweep, ch0, `Period`=100: write 0, 1, 25, 50, 99, 100, 200 → 0, 1, 25, 50, 99, 100, 100 high clocks per period respectively. `period_end_o` pulses every 100 clocks.
- Glitch-free update: ch1 runs at 75. Write 10 at `cnt`=5, then 40 at `cnt`=50 → the current period stays 75 high; the next period is 40 high; the value 10 never appears.
- Commit race: assert `cfg_valid_i` continuously → no handshake occurs in the `cnt`=99 cycle; the write lands in `pend` on the cycle after.
- Enable and reset mid-operation: drop `en_i` at `cnt`=30 → `pwm_o`=0 on the next edge. Re-raise → `cnt` restarts at 0 and there is no `period_end_o` on the first cycle. Repeat with `rst_ni` pulsed at `cnt`=60 → outputs clear asynchronously.
- Under `PWM_CENTER_EN` with `Period`=10 and duty 4: the period is 18 clocks, the output is high for 7 clocks centred on `cnt`=0, and `period_end_o` pulses every 18 clocks.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and helpers for the multi-channel PWM block.
//   DEF_WIDTH / DEF_CHANNELS / DEF_PERIOD : default instance configuration
//   ch_idx_width(n)                       : bits needed to address n channels (min 1)
//   dir_e                                 : triangle-counter direction (UP / DOWN)
package pwm_pkg;

    localparam int unsigned DEF_WIDTH    = 32'd8;
    localparam int unsigned DEF_CHANNELS = 32'd4;
    localparam int unsigned DEF_PERIOD   = 32'd100;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    function automatic int unsigned ch_idx_width(input int unsigned n);
        if (n > 32'd1) begin
            ch_idx_width = $clog2(n);
        end else begin
            ch_idx_width = 32'd1;
        end
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with a double-buffered duty register.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : run enable; low forces the output low and keeps act tracking pend
//   cnt_i         : shared period counter
//   commit_i      : period-boundary strobe, copies pend into act
//   wr_i, duty_i  : duty write strobe and value (lands in pend)
//   pwm_o         : registered output, high while cnt < act
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned Width = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] cnt_i,
    input  logic             commit_i,
    input  logic             wr_i,
    input  logic [Width-1:0] duty_i,
    output logic             pwm_o
);

    logic [Width-1:0] pend_r;
    logic [Width-1:0] act_r;
    logic             pwm_r;

    // Pending duty: last accepted write before the commit wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_r <= {Width{1'b0}};
        end else if (wr_i) begin
            pend_r <= duty_i;
        end else begin
            pend_r <= pend_r;
        end
    end

    // Active duty: only changes at the period boundary, or continuously while
    // stopped so a restart immediately uses the newest duty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_r <= {Width{1'b0}};
        end else if (commit_i || !en_i) begin
            act_r <= pend_r;
        end else begin
            act_r <= act_r;
        end
    end

    // Output comparator flop; act >= period never matches so it stays high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_r <= 1'b0;
        end else if (!en_i) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= (cnt_i < act_r);
        end
    end

    assign pwm_o = pwm_r;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: shared-counter multi-channel PWM generator.
//   clk_i, rst_ni       : clock, async active-low reset
//   en_i                : run enable; low holds the counter at 0 and outputs low
//   cfg_valid_i/ready_o : duty write handshake (ready drops in the commit cycle)
//   cfg_ch_i, cfg_duty_i: target channel and duty in counts (out-of-range channel is dropped)
//   pwm_o               : registered PWM outputs
//   period_end_o        : registered one-cycle pulse in the cycle after each wrap
// Build option: define PWM_CENTER_EN for a triangle (center-aligned) counter;
// the wrap/commit then happens on the down-count step 1 -> 0.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned Width    = DEF_WIDTH,
    parameter int unsigned Channels = DEF_CHANNELS,
    parameter int unsigned Period   = DEF_PERIOD
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                en_i,
    input  logic                                cfg_valid_i,
    output logic                                cfg_ready_o,
    input  logic [ch_idx_width(Channels)-1:0]   cfg_ch_i,
    input  logic [Width-1:0]                    cfg_duty_i,
    output logic [Channels-1:0]                 pwm_o,
    output logic                                period_end_o
);

    localparam int unsigned      CH_W     = ch_idx_width(Channels);
    localparam logic [Width-1:0] LAST_CNT = Width'(Period - 32'd1);
    localparam logic [Width-1:0] ONE      = Width'(32'd1);
    localparam logic [Width-1:0] ZERO     = Width'(32'd0);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 32'd1)'(Channels);

    logic [Width-1:0]    cnt_r;
    logic [Width-1:0]    cnt_nxt_s;
    logic                wrap_s;
    logic                ready_r;
    logic                ready_s;
    logic                wr_ok_s;
    logic                period_end_r;
    logic [Channels-1:0] wr_s;
    logic [Channels-1:0] pwm_s;

`ifdef PWM_CENTER_EN
    dir_e dir_r;
    dir_e dir_nxt_s;

    // Triangle counter: up to Period-1, back down to 1, wrap on 1 -> 0.
    always_comb begin
        cnt_nxt_s = cnt_r;
        dir_nxt_s = dir_r;
        wrap_s    = 1'b0;
        if (!en_i) begin
            cnt_nxt_s = ZERO;
            dir_nxt_s = UP;
        end else if (dir_r == UP) begin
            if (cnt_r == LAST_CNT) begin
                if (Period > 32'd2) begin
                    cnt_nxt_s = cnt_r - ONE;
                    dir_nxt_s = DOWN;
                end else begin
                    // Period 2 has no down leg: treat the top as the wrap.
                    cnt_nxt_s = ZERO;
                    wrap_s    = 1'b1;
                end
            end else begin
                cnt_nxt_s = cnt_r + ONE;
            end
        end else begin
            if (cnt_r == ONE) begin
                cnt_nxt_s = ZERO;
                dir_nxt_s = UP;
                wrap_s    = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r - ONE;
            end
        end
    end

    // Direction flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_r <= UP;
        end else begin
            dir_r <= dir_nxt_s;
        end
    end
`else
    // Edge-aligned counter: 0 .. Period-1, then wrap.
    always_comb begin
        cnt_nxt_s = cnt_r;
        wrap_s    = 1'b0;
        if (!en_i) begin
            cnt_nxt_s = ZERO;
        end else if (cnt_r == LAST_CNT) begin
            cnt_nxt_s = ZERO;
            wrap_s    = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r + ONE;
        end
    end
`endif

    // Handshake: ready is withheld in the commit cycle so no write races the copy.
    always_comb begin
        ready_s = ready_r & ~wrap_s;
        if ({1'b0, cfg_ch_i} < CH_LIMIT) begin
            wr_ok_s = cfg_valid_i & ready_s;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Counter, ready-after-reset flag and period-end pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r        <= ZERO;
            ready_r      <= 1'b0;
            period_end_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            ready_r      <= 1'b1;
            period_end_r <= wrap_s;
        end
    end

    for (genvar k = 0; k < Channels; k++) begin : g_ch
        assign wr_s[k] = wr_ok_s && (cfg_ch_i == CH_W'(k));

        pwm_channel #(
            .Width (Width)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .en_i     (en_i),
            .cnt_i    (cnt_r),
            .commit_i (wrap_s),
            .wr_i     (wr_s[k]),
            .duty_i   (cfg_duty_i),
            .pwm_o    (pwm_s[k])
        );
    end

    assign cfg_ready_o  = ready_s;
    assign period_end_o = period_end_r;
    assign pwm_o        = pwm_s;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized + directed bench for pwm_multi with a position-based
// reference model (counter value derived from elapsed enabled cycles mod period).
module tb_pwm_multi;
    import pwm_pkg::*;

    localparam int CH  = 4;
    localparam int CHW = ch_idx_width(CH);
`ifdef PWM_CENTER_EN
    localparam int P = 10;
    localparam int L = 2 * P - 2;
`else
    localparam int P = 100;
    localparam int L = P;
`endif

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           en_i;
    logic           cfg_valid_i;
    logic           cfg_ready_o;
    logic [CHW-1:0] cfg_ch_i;
    logic [7:0]     cfg_duty_i;
    logic [CH-1:0]  pwm_o;
    logic           period_end_o;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi #(
        .Width    (8),
        .Channels (CH),
        .Period   (P)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_ch_i     (cfg_ch_i),
        .cfg_duty_i   (cfg_duty_i),
        .pwm_o        (pwm_o),
        .period_end_o (period_end_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    int            m_pos = 0;      // enabled cycles since (re)start, mod L
    int            m_pend [CH];
    int            m_act  [CH];
    logic [CH-1:0] m_pwm = '0;
    logic          m_pe  = 1'b0;
    logic          m_rdy = 1'b0;

    function automatic int cnt_of(input int pos);
        int ph;
        ph = pos % L;
        return (ph < P) ? ph : (L - ph);
    endfunction

    function automatic logic m_last(input int pos);
        return (pos % L) == (L - 1);
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_pos <= 0;
            m_rdy <= 1'b0;
            m_pe  <= 1'b0;
            m_pwm <= '0;
            for (int k = 0; k < CH; k++) begin
                m_pend[k] <= 0;
                m_act[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                m_pwm[k] <= en_i && (cnt_of(m_pos) < m_act[k]);
                if (!en_i || m_last(m_pos)) m_act[k] <= m_pend[k];
            end
            if (cfg_valid_i && m_rdy && !(en_i && m_last(m_pos)) && int'(cfg_ch_i) < CH)
                m_pend[cfg_ch_i] <= int'(cfg_duty_i);
            m_pe  <= en_i && m_last(m_pos);
            m_pos <= en_i ? (m_pos + 1) % L : 0;
            m_rdy <= 1'b1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk_i) begin
        check("pwm_o", int'(pwm_o), int'(m_pwm));
        check("period_end_o", int'(period_end_o), int'(m_pe));
        check("cfg_ready_o", int'(cfg_ready_o), int'(m_rdy && !(en_i && m_last(m_pos))));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_write(input int ch, input int duty);
        bit done;
        done        = 1'b0;
        cfg_valid_i = 1'b1;
        cfg_ch_i    = CHW'(ch);
        cfg_duty_i  = 8'(duty);
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            done = cfg_ready_o;
            step();
        end
        cfg_valid_i = 1'b0;
        if (!done) check("write_timeout", 0, 1);
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (cnt_of(m_pos) != v && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check("wait_cnt_timeout", 0, 1);
    endtask

    // high clocks of channel ch over one full period after the next wrap
    task automatic measure(input int ch, output int hi, output int len);
        int n;
        hi = 0;
        len = 0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (period_end_o !== 1'b1 && n < 400);
        if (n >= 400) check("measure_start_timeout", 0, 1);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
            len++;
            if (pwm_o[ch]) hi++;
        end while (period_end_o !== 1'b1 && n < 400);
        if (n >= 400) check("measure_end_timeout", 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int hi;
        int len;
`ifndef PWM_CENTER_EN
        int sweep_duty [7] = '{0, 1, 25, 50, 99, 100, 200};
        int sweep_hi   [7] = '{0, 1, 25, 50, 99, 100, 100};
        int race_exp   [5] = '{1, 1, 0, 1, 1};
`endif
        rst_ni      = 1'b0;
        en_i        = 1'b1;
        cfg_valid_i = 1'b0;
        cfg_ch_i    = '0;
        cfg_duty_i  = 8'd0;

        repeat (3) step();
        check("rst_pwm", int'(pwm_o), 0);
        check("rst_period_end", int'(period_end_o), 0);
        check("rst_ready", int'(cfg_ready_o), 0);
        rst_ni = 1'b1;
        #1;
        check("ready_before_first_edge", int'(cfg_ready_o), 0);
        step();
        check("ready_after_first_edge", int'(cfg_ready_o), 1);

`ifndef PWM_CENTER_EN
        do_write(3, 200);

        // duty sweep on channel 0
        for (int i = 0; i < 7; i++) begin
            do_write(0, sweep_duty[i]);
            measure(0, hi, len);
            check("sweep_high", hi, sweep_hi[i]);
            check("sweep_len", len, 100);
        end

        // glitch-free update on channel 1
        do_write(1, 75);
        measure(1, hi, len);
        check("ch1_75_high", hi, 75);
        wait_cnt(5);
        do_write(1, 10);
        wait_cnt(50);
        do_write(1, 40);
        wait_cnt(61);
        check("ch1_still_75_at_60", int'(pwm_o[1]), 1);
        measure(1, hi, len);
        check("ch1_next_40", hi, 40);

        // commit race with valid held high
        wait_cnt(97);
        cfg_valid_i = 1'b1;
        cfg_ch_i    = CHW'(2);
        for (int i = 0; i < 5; i++) begin
            cfg_duty_i = 8'(30 + i);
            #1;
            check("race_ready", int'(cfg_ready_o), race_exp[i]);
            step();
        end
        cfg_valid_i = 1'b0;

        // enable drop mid-period
        wait_cnt(30);
        en_i = 1'b0;
        step();
        check("en_off_pwm", int'(pwm_o), 0);
        check("en_off_pe", int'(period_end_o), 0);
        repeat (3) step();
        en_i = 1'b1;
        #1;
        check("en_on_first_pe", int'(period_end_o), 0);
        step();
        check("en_on_second_pe", int'(period_end_o), 0);
        measure(0, hi, len);
        check("restart_len", len, 100);

        // async reset mid-period
        wait_cnt(60);
        check("pre_reset_ch3", int'(pwm_o[3]), 1);
        rst_ni = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm_o), 0);
        check("async_rst_ready", int'(cfg_ready_o), 0);
        check("async_rst_pe", int'(period_end_o), 0);
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        check("post_reset_ready", int'(cfg_ready_o), 1);
`else
        do_write(0, 4);
        measure(0, hi, len);
        check("center_high", hi, 7);
        check("center_len", len, 18);
        measure(0, hi, len);
        check("center_len_again", len, 18);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (en_i) begin
                if ($urandom_range(0, 79) == 0) en_i = 1'b0;
            end else begin
                if ($urandom_range(0, 7) == 0) en_i = 1'b1;
            end
            cfg_valid_i = ($urandom_range(0, 3) == 0);
            cfg_ch_i    = CHW'($urandom_range(0, CH - 1));
            case ($urandom_range(0, 3))
                0:       cfg_duty_i = 8'd0;
                1:       cfg_duty_i = 8'(P);
                2:       cfg_duty_i = 8'($urandom_range(0, 255));
                default: cfg_duty_i = 8'($urandom_range(0, P - 1));
            endcase
            if ($urandom_range(0, 999) == 0) begin
                rst_ni = 1'b0;
                step();
                rst_ni = 1'b1;
            end
            step();
        end
        cfg_valid_i = 1'b0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
